sphere_hit_sched: RTL and testbench

- Per-frame controller between sphere_reg_4 and the ray/sphere intersection tester.
- On every Frame_Clk rising edge it scans spheres 0..3: drives Read_index, waits out the register's 1-cycle read latency, and offers each sphere to the tester over a valid/ready handshake.
- Collects hit results into a pending mask and feeds them back to sphere_reg_4 one per frame on Hit/Hit_index.
- Maintains score (consumed hits) and miss (dropped spheres) counters.

---
 rtl/sphere_hit_sched.sv | 129 ++++++++++++
 tb/tb_sphere_hit_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sphere_hit_sched.sv
// Per-frame scan controller: offers spheres 0..3 to the intersection tester,
// collects hits into a pending mask and returns one hit per frame to sphere_reg_4.
`timescale 1ns/1ps
module sphere_hit_sched #(
  parameter int SCORE_W = 16,
  parameter int MISS_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Frame_Clk,
  output logic [1:0]         Read_index,
  output logic               Test_valid,
  output logic [1:0]         Test_index,
  input  logic               Test_ready,
  input  logic               Result_valid,
  input  logic               Result_hit,
  input  logic [1:0]         Result_index,
  input  logic [3:0]         Dropped,
  output logic               Hit,
  output logic [1:0]         Hit_index,
  output logic [SCORE_W-1:0] Score,
  output logic [MISS_W-1:0]  Misses,
  output logic               Busy,
  output logic               Overrun
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, OFFER, DRAIN} state_t;

  state_t      state, state_n;
  logic        fc_old;
  logic        fe;
  logic [1:0]  idx;
  logic [2:0]  rcnt;
  logic [3:0]  pending, pending_n;
  logic [3:0]  set_vec, clr_vec;
  logic [1:0]  low_idx;
  logic [2:0]  drop_cnt;
  logic [MISS_W:0] miss_sum;

  // fc_old starts high so a Frame_Clk already high at release is not an edge.
  assign fe = Frame_Clk && !fc_old;

  // NOTE: every sequential block uses non-blocking assignments and an async
  // reset branch; blocking here would create order-dependent simulation races.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_n unassigned (no latch).
    state_n = state;
    unique case (state)
      IDLE:    if (fe) state_n = ADDR;
      ADDR:    state_n = WAIT;
      WAIT:    state_n = OFFER;
      OFFER:   if (Test_ready) state_n = (idx == 2'd3) ? DRAIN : ADDR;
      DRAIN:   if (rcnt >= 3'd4) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Busy       = (state != IDLE);
    Test_valid = (state == OFFER);
    Test_index = idx;
    Read_index = idx;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_old <= 1'b1;
      idx    <= 2'd0;
      rcnt   <= 3'd0;
    end else begin
      fc_old <= Frame_Clk;
      if (state == IDLE && fe)
        idx <= 2'd0;
      else if (state == OFFER && Test_ready && idx != 2'd3)
        idx <= idx + 2'd1;
      // Stray results beyond four saturate rather than wrap back below the drain threshold.
      if (state == IDLE && fe)
        rcnt <= 3'd0;
      else if (Result_valid && state != IDLE && rcnt != 3'd7)
        rcnt <= rcnt + 3'd1;
    end
  end

  // Clear beats set: a consumed or dropped sphere has just respawned.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (Result_valid && Result_hit && state != IDLE) set_vec[Result_index] = 1'b1;
    if (fe) begin
      clr_vec = Dropped;
      if (Hit) clr_vec[Hit_index] = 1'b1;
    end
    pending_n = (pending | set_vec) & ~clr_vec;
    low_idx = 2'd0;
    if      (pending_n[0]) low_idx = 2'd0;
    else if (pending_n[1]) low_idx = 2'd1;
    else if (pending_n[2]) low_idx = 2'd2;
    else if (pending_n[3]) low_idx = 2'd3;
    drop_cnt = {2'b0, Dropped[0]} + {2'b0, Dropped[1]} +
               {2'b0, Dropped[2]} + {2'b0, Dropped[3]};
    miss_sum = {1'b0, Misses} + (MISS_W+1)'(drop_cnt);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending   <= '0;
      Hit       <= 1'b0;
      Hit_index <= 2'd0;
      Score     <= '0;
      Misses    <= '0;
      Overrun   <= 1'b0;
    end else begin
      pending   <= pending_n;
      Hit       <= |pending_n;
      Hit_index <= low_idx;
      if (fe) begin
        if (Hit && Score != '1) Score <= Score + 1'b1;
        Misses <= miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
        if (state != IDLE) Overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sphere_hit_sched.sv
// Scoreboard bench for sphere_hit_sched: a tester model accepts offers, returns
// results, and expected offer order / counters are compared as the DUT responds.
`timescale 1ns/1ps
module tb_sphere_hit_sched;

  logic        Clk = 1'b0;
  logic        Reset, Frame_Clk, Test_ready, Result_valid, Result_hit;
  logic [1:0]  Result_index;
  logic [3:0]  Dropped;
  logic [1:0]  Read_index, Test_index, Hit_index;
  logic        Test_valid, Hit, Busy, Overrun;
  logic [15:0] Score;
  logic [7:0]  Misses;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  sphere_hit_sched #(.SCORE_W(16), .MISS_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Frame_Clk(Frame_Clk),
    .Read_index(Read_index), .Test_valid(Test_valid), .Test_index(Test_index),
    .Test_ready(Test_ready), .Result_valid(Result_valid), .Result_hit(Result_hit),
    .Result_index(Result_index), .Dropped(Dropped), .Hit(Hit), .Hit_index(Hit_index),
    .Score(Score), .Misses(Misses), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    Reset = 1'b1; Frame_Clk = 1'b1; Test_ready = 1'b1; Result_valid = 1'b0;
    Result_hit = 1'b0; Result_index = 2'd0; Dropped = 4'd0;
    repeat (3) @(negedge Clk);
    n_cmp++; if (Busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %0d expected 0", Busy); end
    n_cmp++; if (Test_valid !== 1'b0) begin n_err++; $display("FAIL rst_test_valid: got %0d expected 0", Test_valid); end
    n_cmp++; if (Read_index !== 2'd0) begin n_err++; $display("FAIL rst_read_index: got %0d expected 0", Read_index); end
    n_cmp++; if (Test_index !== 2'd0) begin n_err++; $display("FAIL rst_test_index: got %0d expected 0", Test_index); end
    n_cmp++; if (Hit !== 1'b0 || Hit_index !== 2'd0) begin n_err++; $display("FAIL rst_hit: got %0d/%0d expected 0/0", Hit, Hit_index); end
    n_cmp++; if (Score !== 16'd0 || Misses !== 8'd0) begin n_err++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", Score, Misses); end
    n_cmp++; if (Overrun !== 1'b0)    begin n_err++; $display("FAIL rst_overrun: got %0d expected 0", Overrun); end
    Reset = 1'b0;
    // Frame_Clk is already high at release: no frame edge may fire.
    repeat (3) @(negedge Clk);
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL no_fe_after_reset: got busy %0d expected 0", Busy); end
    Frame_Clk = 1'b0;
    @(negedge Clk);
  endtask

  // Starts a frame at the current negedge and plays the tester until the scan ends.
  task automatic run_scan(input logic [3:0] hit_mask, input logic [3:0] drop0,
                          input int stall_idx, input int stall_len,
                          input int ovr_at, input logic [3:0] ovr_drop);
    int n = 0, stall_cnt = 0, res_sent = 0, last_n = 0;
    bit first_seen = 0, done = 0, rpend = 0;
    logic [1:0] ridx = 2'd0;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    Frame_Clk = 1'b1; Dropped = drop0; Test_ready = 1'b1;
    while (!done && n < 200) begin
      @(negedge Clk);
      n++;
      Dropped = 4'd0; Result_valid = 1'b0; Result_hit = 1'b0;
      if (n == 2) Frame_Clk = 1'b0;
      if (ovr_at != 0 && n == ovr_at) begin Frame_Clk = 1'b1; Dropped = ovr_drop; end
      if (ovr_at != 0 && n == ovr_at + 2) Frame_Clk = 1'b0;
      if (n == 1) begin
        n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL busy_after_fe: got %0d expected 1", Busy); end
      end
      if (rpend) begin
        Result_valid = 1'b1; Result_index = ridx; Result_hit = hit_mask[ridx];
        rpend = 0; res_sent++; last_n = n;
        if (res_sent == 4) begin
          n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL busy_before_last_result: got %0d expected 1", Busy); end
        end
      end
      if (Test_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          n_cmp++; if (n != 3) begin n_err++; $display("FAIL first_offer_latency: got %0d expected 3", n); end
        end
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL extra_offer: got index %0d expected none", Test_index);
          done = 1;
        end else begin
          n_cmp++; if (Read_index !== 2'(exp_q[0])) begin n_err++; $display("FAIL read_index: got %0d expected %0d", Read_index, exp_q[0]); end
          if (stall_cnt < stall_len && exp_q[0] == stall_idx) begin
            Test_ready = 1'b0; stall_cnt++;
            n_cmp++; if (Test_index !== 2'(stall_idx)) begin n_err++; $display("FAIL stall_hold: got %0d expected %0d", Test_index, stall_idx); end
          end else begin
            Test_ready = 1'b1;
            n_cmp++; if (Test_index !== 2'(exp_q[0])) begin n_err++; $display("FAIL offer_order: got %0d expected %0d", Test_index, exp_q[0]); end
            ridx = 2'(exp_q[0]);
            void'(exp_q.pop_front());
            rpend = 1;
          end
        end
      end else begin
        Test_ready = 1'b1;
      end
      if (res_sent == 4 && n > last_n) begin
        if (!Busy) done = 1;
        else if (n - last_n > 6) begin
          n_cmp++; n_err++; $display("FAIL busy_fall: got busy 1 expected 0 within 6 cycles");
          done = 1;
        end
      end
    end
    if (!done) begin n_cmp++; n_err++; $display("FAIL scan_timeout: got %0d results expected 4", res_sent); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL offers_left: got %0d expected 0", exp_q.size()); end
    n_cmp++; if (stall_cnt != stall_len) begin n_err++; $display("FAIL stall_len: got %0d expected %0d", stall_cnt, stall_len); end
    exp_q.delete();
    Frame_Clk = 1'b0; Dropped = 4'd0; Result_valid = 1'b0; Result_hit = 1'b0; Test_ready = 1'b1;
  endtask

  task automatic test_basic_scan();
    run_scan(4'b0000, 4'b0000, -1, 0, 0, 4'b0000);
    n_cmp++; if (Hit !== 1'b0 || Score !== 16'd0) begin n_err++; $display("FAIL basic_no_hit: got %0d/%0d expected 0/0", Hit, Score); end
  endtask

  task automatic test_stall();
    run_scan(4'b0000, 4'b0000, 1, 5, 0, 4'b0000);
  endtask

  task automatic test_hits();
    run_scan(4'b0101, 4'b0000, -1, 0, 0, 4'b0000);
    n_cmp++; if (Hit !== 1'b1 || Hit_index !== 2'd0) begin n_err++; $display("FAIL hits_first: got %0d/%0d expected 1/0", Hit, Hit_index); end
    run_scan(4'b0000, 4'b0000, -1, 0, 0, 4'b0000);
    n_cmp++; if (Score !== 16'd1) begin n_err++; $display("FAIL hits_score1: got %0d expected 1", Score); end
    n_cmp++; if (Hit !== 1'b1 || Hit_index !== 2'd2) begin n_err++; $display("FAIL hits_second: got %0d/%0d expected 1/2", Hit, Hit_index); end
    run_scan(4'b0000, 4'b0000, -1, 0, 0, 4'b0000);
    n_cmp++; if (Score !== 16'd2 || Hit !== 1'b0) begin n_err++; $display("FAIL hits_drained: got %0d/%0d expected 2/0", Score, Hit); end
  endtask

  task automatic test_drop_consume();
    run_scan(4'b0100, 4'b0000, -1, 0, 0, 4'b0000);
    n_cmp++; if (Hit !== 1'b1 || Hit_index !== 2'd2) begin n_err++; $display("FAIL drop_setup: got %0d/%0d expected 1/2", Hit, Hit_index); end
    run_scan(4'b0000, 4'b0100, -1, 0, 0, 4'b0000);
    n_cmp++; if (Score !== 16'd3 || Misses !== 8'd1) begin n_err++; $display("FAIL drop_counters: got %0d/%0d expected 3/1", Score, Misses); end
    n_cmp++; if (Hit !== 1'b0) begin n_err++; $display("FAIL drop_cleared: got %0d expected 0", Hit); end
  endtask

  // Second frame edge lands on the index-1 hit result with Dropped[1] set.
  task automatic test_overrun();
    run_scan(4'b0010, 4'b0000, -1, 0, 7, 4'b0010);
    n_cmp++; if (Overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %0d expected 1", Overrun); end
    n_cmp++; if (Hit !== 1'b0) begin n_err++; $display("FAIL clear_beats_set: got %0d expected 0", Hit); end
    n_cmp++; if (Misses !== 8'd2 || Score !== 16'd3) begin n_err++; $display("FAIL overrun_counters: got %0d/%0d expected 2/3", Misses, Score); end
    repeat (4) begin
      @(negedge Clk);
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL no_restart: got %0d expected 0", Busy); end
    end
    run_scan(4'b0000, 4'b0000, -1, 0, 0, 4'b0000);
    n_cmp++; if (Overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %0d expected 1", Overrun); end
  endtask

  // Leaves the DUT stalled in OFFER for index 0.
  task automatic test_misses_saturate();
    int w = 0;
    Test_ready = 1'b0; Frame_Clk = 1'b1;
    @(negedge Clk);
    Frame_Clk = 1'b0;
    while (!Test_valid && w < 10) begin @(negedge Clk); w++; end
    n_cmp++; if (Test_valid !== 1'b1) begin n_err++; $display("FAIL sat_offer: got %0d expected 1", Test_valid); end
    for (int i = 0; i < 63; i++) begin
      Frame_Clk = 1'b1; Dropped = 4'hF;
      @(negedge Clk);
      Frame_Clk = 1'b0; Dropped = 4'h0;
      @(negedge Clk);
    end
    n_cmp++; if (Misses !== 8'd254) begin n_err++; $display("FAIL misses_254: got %0d expected 254", Misses); end
    for (int i = 0; i < 2; i++) begin
      Frame_Clk = 1'b1; Dropped = 4'hF;
      @(negedge Clk);
      Frame_Clk = 1'b0; Dropped = 4'h0;
      @(negedge Clk);
      n_cmp++; if (Misses !== 8'd255) begin n_err++; $display("FAIL misses_sat: got %0d expected 255", Misses); end
    end
    n_cmp++; if (Test_valid !== 1'b1 || Test_index !== 2'd0) begin n_err++; $display("FAIL sat_offer_held: got %0d/%0d expected 1/0", Test_valid, Test_index); end
    n_cmp++; if (Score !== 16'd3) begin n_err++; $display("FAIL sat_score: got %0d expected 3", Score); end
  endtask

  task automatic test_reset_mid_scan();
    Result_valid = 1'b1; Result_hit = 1'b1; Result_index = 2'd1;
    @(negedge Clk);
    Result_index = 2'd3;
    @(negedge Clk);
    Result_valid = 1'b0; Result_hit = 1'b0;
    @(negedge Clk);
    n_cmp++; if (Hit !== 1'b1 || Hit_index !== 2'd1) begin n_err++; $display("FAIL pend_1010: got %0d/%0d expected 1/1", Hit, Hit_index); end
    n_cmp++; if (Test_valid !== 1'b1) begin n_err++; $display("FAIL still_offer: got %0d expected 1", Test_valid); end
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (Hit !== 1'b0 || Test_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_out: got %0d/%0d expected 0/0", Hit, Test_valid); end
    n_cmp++; if (Score !== 16'd0 || Misses !== 8'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d/%0d expected 0/0", Score, Misses); end
    n_cmp++; if (Overrun !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL async_rst_flags: got %0d/%0d expected 0/0", Overrun, Busy); end
    @(negedge Clk);
    Reset = 1'b0; Test_ready = 1'b1;
    @(negedge Clk);
    Result_valid = 1'b1; Result_hit = 1'b1; Result_index = 2'd2;
    @(negedge Clk);
    Result_valid = 1'b0; Result_hit = 1'b0;
    @(negedge Clk);
    n_cmp++; if (Hit !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL idle_result_ignored: got %0d/%0d expected 0/0", Hit, Busy); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_stall();
    test_hits();
    test_drop_consume();
    test_overrun();
    test_misses_saturate();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
